// File: rtl/dbus_issue.sv
// dbus_issue: M-stage data-bus initiator; issues one load/store, runs addr_ok/data_ok, stalls until done.
// Ports: clk/resetn (sync, active low); op_* memory op from M stage; dreq_* request bus
// {valid,addr,size,strobe,data}; dresp_* response {addr_ok,data_ok,data}; stall_m freezes F/D/E/M;
// done/rdata/raddr_lo hand the completed load to write-back; misalign flags rejected ops.
module dbus_issue #(
  parameter bit          ENABLE_TRANSLATE = 1'b1,
  parameter logic [31:0] PHYS_MASK        = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        stall_m,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  raddr_lo,
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [1:0]  size_q;
  logic [3:0]  strobe_q, strobe_d;
  logic        mem, bad, accept;
  always_comb begin
    mem      = op_valid & (op_load | op_store);
    bad      = (op_size == 2'd3) | (op_size == 2'd1 & op_addr[0]) | (op_size == 2'd2 & |op_addr[1:0]);
    accept   = (state_q == IDLE) & mem & ~bad;
    misalign = (state_q == IDLE) & mem & bad;
    // kseg0/kseg1 (top bits 2'b10) fold onto physical memory; mask keeps addr[1:0]
    addr_d   = (ENABLE_TRANSLATE && op_addr[31:30] == 2'b10) ? (op_addr & PHYS_MASK) : op_addr;
    strobe_d = !op_store ? 4'b0000 :
               op_size == 2'd0 ? 4'b0001 << op_addr[1:0] :
               op_size == 2'd1 ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    data_d   = op_size == 2'd0 ? {4{op_wdata[7:0]}} :
               op_size == 2'd1 ? {2{op_wdata[15:0]}} : op_wdata;
    done     = (state_q == REQ & dresp_addr_ok & dresp_data_ok) | (state_q == WAIT & dresp_data_ok);
    stall_m  = accept | ((state_q != IDLE) & ~done);
    rdata    = done ? dresp_data : 32'd0;
    raddr_lo = done ? addr_q[1:0] : 2'd0;
    dreq_valid  = state_q == REQ;
    dreq_addr   = dreq_valid ? addr_q : 32'd0;
    dreq_size   = dreq_valid ? size_q : 2'd0;
    dreq_strobe = dreq_valid ? strobe_q : 4'd0;
    dreq_data   = dreq_valid ? data_q : 32'd0;
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = accept ? REQ : IDLE;
      REQ:     state_d = dresp_addr_ok ? (dresp_data_ok ? IDLE : WAIT) : REQ;
      WAIT:    state_d = dresp_data_ok ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr_d;
        size_q   <= op_size;
        strobe_q <= strobe_d;
        data_q   <= data_d;
      end
    end
  end
endmodule

// File: tb/tb_dbus_issue.sv
// tb_dbus_issue: directed checks of dbus_issue with translation on (u0) and off (u1).
module tb_dbus_issue;
  logic        clk = 1'b0, resetn;
  logic        op_valid, op_load, op_store;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic        aok, dok;
  logic [31:0] rd;
  logic        v0, v1, st0, st1, dn0, dn1, mis0, mis1;
  logic [31:0] a0, a1, d0, d1, r0, r1;
  logic [1:0]  s0, s1, lo0, lo1;
  logic [3:0]  sb0, sb1;
  int total = 0, bad = 0, stalls;

  always #5 clk = ~clk;

  dbus_issue u0 (.clk(clk), .resetn(resetn), .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata), .dreq_valid(v0), .dreq_addr(a0),
    .dreq_size(s0), .dreq_strobe(sb0), .dreq_data(d0), .dresp_addr_ok(aok), .dresp_data_ok(dok),
    .dresp_data(rd), .stall_m(st0), .done(dn0), .rdata(r0), .raddr_lo(lo0), .misalign(mis0));

  dbus_issue #(.ENABLE_TRANSLATE(1'b0)) u1 (.clk(clk), .resetn(resetn), .op_valid(op_valid),
    .op_load(op_load), .op_store(op_store), .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata),
    .dreq_valid(v1), .dreq_addr(a1), .dreq_size(s1), .dreq_strobe(sb1), .dreq_data(d1),
    .dresp_addr_ok(aok), .dresp_data_ok(dok), .dresp_data(rd), .stall_m(st1), .done(dn1), .rdata(r1),
    .raddr_lo(lo1), .misalign(mis1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] wd);
    op_valid = v; op_load = ld; op_store = st; op_size = sz; op_addr = a; op_wdata = wd;
  endtask

  task automatic resp(input logic ao, input logic dk, input logic [31:0] d);
    aok = ao; dok = dk; rd = d;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_valid"}, {31'd0, v0}, 32'd0);
    chk({tag, "_stall"}, {31'd0, st0}, 32'd0);
    chk({tag, "_done"}, {31'd0, dn0}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    resp(0, 0, 32'd0);
    nxt(); nxt();
    #1;
    quiet("rst");
    chk("rst_rdata", r0, 32'd0);
    chk("rst_lo", {30'd0, lo0}, 32'd0);
    chk("rst_mis", {31'd0, mis0}, 32'd0);
    chk("rst_addr", a0, 32'd0);
    resetn = 1'b1;
    nxt();
    // LW kseg0, immediate response
    op(1, 1, 0, 2'd2, 32'h8000_0104, 32'd0);
    #1;
    chk("lw_acc_stall", {31'd0, st0}, 32'd1);
    chk("lw_acc_valid", {31'd0, v0}, 32'd0);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    resp(1, 1, 32'hDEAD_BEEF);
    #1;
    chk("lw_valid", {31'd0, v0}, 32'd1);
    chk("lw_addr", a0, 32'h0000_0104);
    chk("lw_addr_notr", a1, 32'h8000_0104);
    chk("lw_size", {30'd0, s0}, 32'd2);
    chk("lw_strobe", {28'd0, sb0}, 32'd0);
    chk("lw_done", {31'd0, dn0}, 32'd1);
    chk("lw_rdata", r0, 32'hDEAD_BEEF);
    chk("lw_stall", {31'd0, st0}, 32'd0);
    nxt();
    resp(0, 0, 32'd0);
    #1;
    quiet("lw_after");
    // SB kseg1, addr_ok after 3 REQ cycles, data_ok 2 cycles later
    stalls = 0;
    op(1, 0, 1, 2'd0, 32'hA000_0003, 32'h1234_5678);
    #1;
    stalls += int'(st0);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      stalls += int'(st0);
      chk("sb_valid", {31'd0, v0}, 32'd1);
      chk("sb_addr", a0, 32'h0000_0003);
      chk("sb_size", {30'd0, s0}, 32'd0);
      chk("sb_strobe", {28'd0, sb0}, 32'h8);
      chk("sb_data", d0, 32'h7878_7878);
      nxt();
    end
    resp(1, 0, 32'd0);
    #1;
    stalls += int'(st0);
    chk("sb_aok_valid", {31'd0, v0}, 32'd1);
    chk("sb_aok_done", {31'd0, dn0}, 32'd0);
    nxt();
    resp(0, 0, 32'd0);
    #1;
    stalls += int'(st0);
    chk("sb_wait_valid", {31'd0, v0}, 32'd0);
    chk("sb_wait_done", {31'd0, dn0}, 32'd0);
    nxt();
    resp(0, 1, 32'h0);
    #1;
    stalls += int'(st0);
    chk("sb_done", {31'd0, dn0}, 32'd1);
    chk("sb_stalls", stalls, 32'd6);
    nxt();
    resp(0, 0, 32'd0);
    // SH: translation on vs off
    op(1, 0, 1, 2'd1, 32'h8000_0006, 32'h0000_ABCD);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    resp(1, 1, 32'd0);
    #1;
    chk("sh_addr_tr", a0, 32'h0000_0006);
    chk("sh_addr_notr", a1, 32'h8000_0006);
    chk("sh_strobe", {28'd0, sb1}, 32'hC);
    chk("sh_data", d1, 32'hABCD_ABCD);
    chk("sh_done_notr", {31'd0, dn1}, 32'd1);
    nxt();
    resp(0, 0, 32'd0);
    // Misaligned / illegal ops
    op(1, 1, 0, 2'd1, 32'h0000_0003, 32'd0);
    #1;
    chk("lh_mis", {31'd0, mis0}, 32'd1);
    quiet("lh");
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    #1;
    chk("lh_mis_clr", {31'd0, mis0}, 32'd0);
    quiet("lh_after");
    op(1, 1, 0, 2'd3, 32'h0000_0000, 32'd0);
    #1;
    chk("sz3_mis", {31'd0, mis0}, 32'd1);
    chk("sz3_stall", {31'd0, st0}, 32'd0);
    nxt();
    op(1, 0, 1, 2'd2, 32'h0000_0002, 32'd0);
    #1;
    chk("sw_mis", {31'd0, mis0}, 32'd1);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    #1;
    quiet("sw_after");
    // Reset while in WAIT, then a stale data_ok
    op(1, 1, 0, 2'd2, 32'h0000_0020, 32'd0);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    resp(1, 0, 32'd0);
    nxt();
    resp(0, 0, 32'd0);
    #1;
    chk("wait_stall", {31'd0, st0}, 32'd1);
    chk("wait_valid", {31'd0, v0}, 32'd0);
    resetn = 1'b0;
    nxt();
    resetn = 1'b1;
    #1;
    quiet("postrst");
    resp(0, 1, 32'h5555_5555);
    #1;
    quiet("stale");
    chk("stale_rdata", r0, 32'd0);
    nxt();
    resp(0, 0, 32'd0);
    #1;
    quiet("stale_after");
    // Back-to-back LBs
    op(1, 1, 0, 2'd0, 32'h0000_0010, 32'd0);
    #1;
    chk("lb0_acc_stall", {31'd0, st0}, 32'd1);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    resp(1, 1, 32'h0000_00A1);
    #1;
    chk("lb0_valid", {31'd0, v0}, 32'd1);
    chk("lb0_addr", a0, 32'h0000_0010);
    chk("lb0_strobe", {28'd0, sb0}, 32'd0);
    chk("lb0_done", {31'd0, dn0}, 32'd1);
    chk("lb0_lo", {30'd0, lo0}, 32'd0);
    nxt();
    resp(0, 0, 32'd0);
    op(1, 1, 0, 2'd0, 32'h0000_0011, 32'd0);
    #1;
    chk("lb1_acc_stall", {31'd0, st0}, 32'd1);
    chk("lb1_acc_valid", {31'd0, v0}, 32'd0);
    nxt();
    op(0, 0, 0, 2'd0, 32'd0, 32'd0);
    resp(1, 1, 32'h0000_B200);
    #1;
    chk("lb1_valid", {31'd0, v0}, 32'd1);
    chk("lb1_addr", a0, 32'h0000_0011);
    chk("lb1_done", {31'd0, dn0}, 32'd1);
    chk("lb1_lo", {30'd0, lo0}, 32'd1);
    chk("lb1_rdata", r0, 32'h0000_B200);
    nxt();
    resp(0, 0, 32'd0);
    #1;
    quiet("end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbus_issue.md
Name: dbus_issue

Overview:
- Memory-stage initiator for the data bus. It accepts one load/store per M-stage slot and drives dbus_req_t with the translated address, size, byte strobe and lane-replicated store data.
- It runs the addr_ok/data_ok handshake and stalls the pipeline until the response returns.
- It hands load data and address low bits to the write-back stage for byte/half extraction.
- It is the request-side counterpart of the load-data consumer in WriteBack.

Parameters:
- ENABLE_TRANSLATE, 1, when 1, addresses in 0x8000_0000–0xBFFF_FFFF are masked to physical; when 0, the address passes through.
- PHYS_MASK, 32'h1FFF_FFFF, mask applied to kseg0/kseg1 addresses.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  synchronous reset, active low.
- op_valid  in  1  M-stage slot holds a memory op this cycle.
- op_load  in  1  op is a load.
- op_store  in  1  op is a store; op_load and op_store are never both 1.
- op_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- op_addr  in  32  virtual effective address (valE).
- op_wdata  in  32  store source register value.
- dreq  out  dbus_req_t  {valid, addr, size, strobe, data}.
- dresp  in  dbus_resp_t  {addr_ok, data_ok, data}.
- stall_m  out  1  freeze F/D/E/M registers this cycle.
- done  out  1  op completed this cycle.
- rdata  out  32  raw response word, valid when done.
- raddr_lo  out  2  op_addr[1:0] of the completing op.
- misalign  out  1  op rejected as misaligned or illegal size.

Behaviour:
- States: IDLE, REQ, WAIT. Reset (resetn=0 at posedge) forces IDLE and clears all registered request fields.
- Outputs in IDLE with no accept: dreq all zero, stall_m=0, done=0, rdata=0, raddr_lo=0, misalign=0.
- Misalign check (combinational in IDLE when op_valid & (op_load|op_store)):
  - size 1 with addr[0]≠0 → misaligned.
  - size 2 with addr[1:0]≠0 → misaligned.
  - size 3 → illegal.
  - Result: misalign=1 that cycle, no request, stall_m=0, state stays IDLE.
- Accept: in IDLE with a valid, aligned op, latch the request fields, set stall_m=1 in the same cycle, and move to REQ at the next edge.
- Field encoding:
  - addr: translated physical address with bits [1:0] kept.
  - size: MSIZE1 / MSIZE2 / MSIZE4.
  - strobe, loads: 4'b0000.
  - strobe, byte stores: 4'b0001 << addr[1:0].
  - strobe, half stores: addr[1] ? 4'b1100 : 4'b0011.
  - strobe, word stores: 4'b1111.
  - data, byte: {4{wdata[7:0]}}; half: {2{wdata[15:0]}}; word: wdata.
- REQ:
  - dreq.valid=1 with latched fields. Fields must not change while valid=1 and addr_ok=0.
  - addr_ok=0 → stay in REQ.
  - addr_ok=1 and data_ok=0 → go to WAIT; dreq.valid=0 from the next cycle.
  - addr_ok=1 and data_ok=1 in the same cycle → complete immediately and return to IDLE.
  - data_ok=1 without addr_ok is ignored.
- WAIT: dreq.valid=0; stay until data_ok=1, then complete and return to IDLE.
- Completion cycle:
  - done=1, rdata=dresp.data, raddr_lo=latched addr[1:0], stall_m=0, so the pipeline advances on that edge.
  - For stores, rdata is don't-care.
- stall_m=1 in every REQ/WAIT cycle except the completion cycle.
- Back-to-back ops: a new op may be accepted in the IDLE cycle right after completion. A minimum op costs 2 cycles: accept, then REQ with addr_ok & data_ok.
- data_ok arriving in IDLE (stale, e.g. after reset) is ignored and produces no done.
- Reset mid-operation: abandon the transaction and return to IDLE. dreq.valid=0 and stall_m=0 from the cycle after the reset edge.
- No queuing: at most one outstanding transaction.

Test Plan:
- LW addr=0x8000_0104, addr_ok and data_ok both in the REQ cycle, data=0xDEADBEEF → dreq.addr=0x0000_0104, size=MSIZE4, strobe=0; done=1 with rdata=0xDEADBEEF 1 cycle after accept; stall_m high exactly 1 cycle (the accept cycle).
- SB addr=0xA000_0003, wdata=0x12345678, addr_ok delayed 3 cycles, data_ok 2 cycles later → dreq.addr=0x0000_0003, strobe=4'b1000, data=0x78787878, fields stable while waiting; stall_m high 6 cycles; done in the data_ok cycle.
- SH addr=0x0000_0006, wdata=0x0000ABCD, ENABLE_TRANSLATE=0 → addr unchanged, strobe=4'b1100, data=0xABCDABCD.
- LH addr=0x0000_0003 → misalign=1 for 1 cycle, dreq.valid never asserted, stall_m=0; same for op_size=3.
- Assert resetn=0 while in WAIT, then deliver data_ok=1 in IDLE → no done, state IDLE, dreq.valid=0, stall_m=0.
- Two back-to-back LBs at 0x10 and 0x11 with immediate responses → two requests 2 cycles apart; raddr_lo=0 then 1 at the respective done cycles.
